// File: rtl/reg_file_scoreboard_pkg.sv
// Shared widths, typedefs and helpers for the register file / load scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-back to ID bypass).
package reg_file_scoreboard_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
   localparam int unsigned CNT_W    = ADDR_W + 1;

   typedef logic [ADDR_W-1:0]   regaddr_t;
   typedef logic [DATA_W-1:0]   word_t;
   typedef logic [CNT_W-1:0]    cnt_t;
   typedef logic [NUM_REGS-1:0] pend_t;

   localparam regaddr_t ZERO_REG = '0;

   // Number of set bits in a pending vector.
   function automatic cnt_t popcount(input pend_t v);
      cnt_t n;
      n = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         n = n + cnt_t'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// ID/WB facing signal bundle of the register file; master drives the pipeline side.
// Optional feature macro: REGFILE_BYPASS_EN (affects only the slave's behaviour).
interface reg_file_scoreboard_if;
   import reg_file_scoreboard_pkg::*;

   logic     wb_regwrite;
   regaddr_t wb_write_addr;
   word_t    wb_write_data;
   logic     wb_is_load;
   regaddr_t rs_addr;
   regaddr_t rt_addr;
   word_t    rs_data;
   word_t    rt_data;
   logic     id_issue;
   logic     id_is_load;
   regaddr_t id_dest_addr;
   logic     stall;
   cnt_t     pending_count;

   modport master (
      output wb_regwrite, wb_write_addr, wb_write_data, wb_is_load,
      output rs_addr, rt_addr, id_issue, id_is_load, id_dest_addr,
      input  rs_data, rt_data, stall, pending_count
   );

   modport slave (
      input  wb_regwrite, wb_write_addr, wb_write_data, wb_is_load,
      input  rs_addr, rt_addr, id_issue, id_is_load, id_dest_addr,
      output rs_data, rt_data, stall, pending_count
   );

endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Load scoreboard: pending bit per register, set on load issue, cleared on load write-back.
// REGFILE_BYPASS_EN lets a bit being cleared this cycle stop stalling immediately.
module reg_scoreboard
   import reg_file_scoreboard_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     wb_regwrite_i,
   input  regaddr_t wb_write_addr_i,
   input  logic     wb_is_load_i,
   input  regaddr_t rs_addr_i,
   input  regaddr_t rt_addr_i,
   input  logic     id_issue_i,
   input  logic     id_is_load_i,
   input  regaddr_t id_dest_addr_i,
   output logic     stall_o,
   output cnt_t     pending_count_o
);

   pend_t pend_q, pend_d;
   pend_t pend_view;
   cnt_t  count_q, count_d;
   logic  set_c, clr_c;

   assign clr_c = wb_regwrite_i & wb_is_load_i;
   assign set_c = id_issue_i & id_is_load_i & (id_dest_addr_i != ZERO_REG) & ~stall_o;

   // Pending view used by the stall compare.
   always_comb begin
      pend_view = pend_q;
`ifdef REGFILE_BYPASS_EN
      if (clr_c) begin
         pend_view[wb_write_addr_i] = 1'b0;
      end
`endif
   end

   assign stall_o = ((rs_addr_i != ZERO_REG) & pend_view[rs_addr_i])
                  | ((rt_addr_i != ZERO_REG) & pend_view[rt_addr_i]);

   // Clear first so a same-address set from the younger load wins.
   always_comb begin
      pend_d = pend_q;
      if (clr_c) begin
         pend_d[wb_write_addr_i] = 1'b0;
      end
      if (set_c) begin
         pend_d[id_dest_addr_i] = 1'b1;
      end
      pend_d[ZERO_REG] = 1'b0;
      count_d = popcount(pend_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= '0;
         count_q <= '0;
      end else begin
         pend_q  <= pend_d;
         count_q <= count_d;
      end
   end

   assign pending_count_o = count_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file (r0 hardwired zero) with two ID read ports and one WB write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module reg_file_scoreboard
   import reg_file_scoreboard_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   reg_file_scoreboard_if.slave rf
);

   word_t regs_q [NUM_REGS];
   word_t regs_d [NUM_REGS];
   word_t rs_c, rt_c;

   // Write port; r0 writes are dropped.
   always_comb begin
      regs_d = regs_q;
      if (rf.wb_regwrite && (rf.wb_write_addr != ZERO_REG)) begin
         regs_d[rf.wb_write_addr] = rf.wb_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports with optional write-back forwarding.
   always_comb begin
      rs_c = regs_q[rf.rs_addr];
      rt_c = regs_q[rf.rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (rf.wb_regwrite && (rf.wb_write_addr == rf.rs_addr)) begin
         rs_c = rf.wb_write_data;
      end
      if (rf.wb_regwrite && (rf.wb_write_addr == rf.rt_addr)) begin
         rt_c = rf.wb_write_data;
      end
`endif
      if (rf.rs_addr == ZERO_REG) begin
         rs_c = '0;
      end
      if (rf.rt_addr == ZERO_REG) begin
         rt_c = '0;
      end
   end

   assign rf.rs_data = rs_c;
   assign rf.rt_data = rt_c;

   reg_scoreboard u_sb (
      .clk             (clk),
      .reset           (reset),
      .wb_regwrite_i   (rf.wb_regwrite),
      .wb_write_addr_i (rf.wb_write_addr),
      .wb_is_load_i    (rf.wb_is_load),
      .rs_addr_i       (rf.rs_addr),
      .rt_addr_i       (rf.rt_addr),
      .id_issue_i      (rf.id_issue),
      .id_is_load_i    (rf.id_is_load),
      .id_dest_addr_i  (rf.id_dest_addr),
      .stall_o         (rf.stall),
      .pending_count_o (rf.pending_count)
   );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: directed plan then random traffic vs. a set-based model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_reg_file_scoreboard;
   import reg_file_scoreboard_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_file_scoreboard_if rf_if ();

   reg_file_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_if)
   );

   typedef struct {
      word_t rs;
      word_t rt;
      logic  stall;
      cnt_t  cnt;
      int    step;
   } exp_t;

   exp_t  exp_q [$];
   int    checks = 0;
   int    errors = 0;
   int    step   = 0;

   // Reference model: register contents plus the set of registers awaiting a load.
   word_t m_regs [NUM_REGS];
   bit    m_pend [int];

   function automatic bit m_pending(input regaddr_t a, input bit wbw, input bit wbl,
                                    input regaddr_t wa);
      if (a == 0) return 1'b0;
      if (!m_pend.exists(int'(a))) return 1'b0;
      if (BYP && wbw && wbl && wa == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic word_t m_read(input regaddr_t a, input bit wbw, input regaddr_t wa,
                                    input word_t wd);
      if (a == 0) return '0;
      if (BYP && wbw && wa == a) return wd;
      return m_regs[a];
   endfunction

   task automatic cyc(input bit rst, input bit wbw, input regaddr_t wa, input word_t wd,
                      input bit wbl, input regaddr_t rs, input regaddr_t rt,
                      input bit iss, input bit ild, input regaddr_t dest);
      exp_t e;
      bit   st;
      reset               = rst;
      rf_if.wb_regwrite   = wbw;
      rf_if.wb_write_addr = wa;
      rf_if.wb_write_data = wd;
      rf_if.wb_is_load    = wbl;
      rf_if.rs_addr       = rs;
      rf_if.rt_addr       = rt;
      rf_if.id_issue      = iss;
      rf_if.id_is_load    = ild;
      rf_if.id_dest_addr  = dest;
      st      = m_pending(rs, wbw, wbl, wa) | m_pending(rt, wbw, wbl, wa);
      e.rs    = m_read(rs, wbw, wa, wd);
      e.rt    = m_read(rt, wbw, wa, wd);
      e.stall = st;
      e.cnt   = cnt_t'(m_pend.num());
      e.step  = step;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      step++;
      if (rst) begin
         m_pend.delete();
         foreach (m_regs[i]) m_regs[i] = '0;
      end else begin
         if (wbw && wbl && m_pend.exists(int'(wa))) m_pend.delete(int'(wa));
         if (iss && ild && dest != 0 && !st) m_pend[int'(dest)] = 1'b1;
         if (wbw && wa != 0) m_regs[wa] = wd;
      end
   endtask

   task automatic rd(input regaddr_t rs, input regaddr_t rt);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, rs, rt, 1'b0, 1'b0, '0);
   endtask

   task automatic chk(input string name, input int stp, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, stp, act, req);
      end
   endtask

   // Monitor: compare the DUT against the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rs_data", e.step, rf_if.rs_data, e.rs);
         chk("rt_data", e.step, rf_if.rt_data, e.rt);
         chk("stall", e.step, DATA_W'(rf_if.stall), DATA_W'(e.stall));
         chk("pending_count", e.step, DATA_W'(rf_if.pending_count), DATA_W'(e.cnt));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      reset               = 1'b1;
      rf_if.wb_regwrite   = 1'b0;
      rf_if.wb_write_addr = '0;
      rf_if.wb_write_data = '0;
      rf_if.wb_is_load    = 1'b0;
      rf_if.rs_addr       = '0;
      rf_if.rt_addr       = '0;
      rf_if.id_issue      = 1'b0;
      rf_if.id_is_load    = 1'b0;
      rf_if.id_dest_addr  = '0;
      foreach (m_regs[i]) m_regs[i] = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      rd(5'd5, 5'd0);
      // Write r7 then read it back; r0 write is dropped
      cyc(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, '0);
      rd(5'd7, 5'd7);
      cyc(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd7, 1'b0, 1'b0, '0);
      rd(5'd0, 5'd0);
      // Load-use on r3
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3);
      rd(5'd3, 5'd0);
      rd(5'd3, 5'd0);
      cyc(1'b0, 1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, '0);
      rd(5'd3, 5'd3);
      // Same-cycle set and clear of r9
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
      cyc(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
      rd(5'd9, 5'd0);
      cyc(1'b0, 1'b1, 5'd9, 32'hA9, 1'b1, 5'd0, 5'd9, 1'b0, 1'b0, '0);
      rd(5'd9, 5'd9);
      // Blocked issue: load reads its own pending source
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd6, 5'd0, 1'b1, 1'b1, 5'd8);
      rd(5'd8, 5'd6);
      // Three loads then reset mid-sequence
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4);
      rd(5'd1, 5'd4);
      cyc(1'b1, 1'b1, 5'd10, 32'hFFFF_FFFF, 1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd11);
      rd(5'd7, 5'd3);
      rd(5'd1, 5'd2);
      // Load to r0 never marks anything
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
      rd(5'd0, 5'd0);

      // Random traffic over a narrow address range to force collisions
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 1)),
             regaddr_t'($urandom_range(0, 7)),
             word_t'($urandom),
             1'($urandom_range(0, 1)),
             regaddr_t'($urandom_range(0, 7)),
             regaddr_t'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             regaddr_t'($urandom_range(0, 7)));
      end
      rd('0, '0);

      for (int w = 0; w < 8 && exp_q.size() != 0; w++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Architectural register file plus load scoreboard that consumes the write-back stage's selected result (register write port) and serves the ID stage (two read ports). Loads issuing from ID mark their destination register pending. The write-back of that load clears the mark. ID reads of a pending source raise a stall so the pipeline holds until the loaded value lands.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero
- ADDR_W, 5, register address width, clog2(NUM_REGS)

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  synchronous, active-high
- wb_regwrite  in  1  write-back write enable
- wb_write_addr  in  ADDR_W  write-back destination
- wb_write_data  in  DATA_W  write-back data (ALU result / load data / PC+4 as selected upstream)
- wb_is_load  in  1  the write-back instruction is a load (clears scoreboard bit)
- rs_addr, rt_addr  in  ADDR_W  ID source addresses
- rs_data, rt_data  out  DATA_W  ID source data, combinational
- id_issue  in  1  an instruction leaves ID this cycle
- id_is_load  in  1  issuing instruction is a load
- id_dest_addr  in  ADDR_W  issuing instruction destination
- stall  out  1  ID must hold, combinational
- pending_count  out  ADDR_W+1  number of pending registers, registered

## Operation
- Register write: on clk edge, if wb_regwrite and wb_write_addr != 0, reg[wb_write_addr] <= wb_write_data. Writes to 0 are dropped.
- Read: rs_data = reg[rs_addr], rt_data = reg[rt_addr]. Address 0 always returns 0.
- Scoreboard: NUM_REGS-bit vector pend.
  - Set pend[id_dest_addr] on id_issue & id_is_load & id_dest_addr != 0 & !stall.
  - Clear pend[wb_write_addr] on wb_regwrite & wb_is_load.
- Same address set and cleared in one cycle: set wins, because the issuing load is younger.
- stall = (rs_addr != 0 & pend[rs_addr]) | (rt_addr != 0 & pend[rt_addr]), with the bypass modification given under Configuration.
- pending_count = popcount of next pend value, registered. Range 0..NUM_REGS-1; no overflow is possible because bit 0 never sets.
- Clearing a bit that is not set is harmless; pend is unchanged.

## Timing
- Reset values:
  - All registers 0.
  - pend all 0.
  - pending_count 0.
  - stall 0, provided no pend bit is set.
  - rs_data and rt_data read 0.
- Reset asserted mid-operation discards all pending marks and register contents on that edge. Inputs are ignored while reset is high.
- Write latency: 1 edge. The value is readable from the following cycle, or in the same cycle when bypass is compiled in.
- A scoreboard set is visible on stall from the cycle after issue.
- A scoreboard clear at WB releases stall on the next cycle, or in the same cycle when bypass is compiled in.
- Back-to-back loads to the same destination: the second load's issue is blocked only if that load itself reads the pending register. Otherwise the bit stays set until a load write-back occurs with no concurrent set.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_regwrite and wb_write_addr == a read address != 0, that read port returns wb_write_data.
  - stall ignores a pend bit being cleared in the current cycle.
- Undefined:
  - Reads return the pre-write register value.
  - stall uses only the registered pend.
  - Load-use costs one extra bubble.

## Structure
- Shared package holds:
  - DATA_W, NUM_REGS, ADDR_W
  - ZERO_REG = 0
  - the regaddr_t / word_t typedefs used by both ID and WB.
- One sub-module, reg_scoreboard. It holds pend, the set/clear priority, pending_count and the stall compare. The top-level block keeps the storage array and read/bypass muxing.

## Test plan
- Reset, then read rs=5, rt=0 -> rs_data=0, rt_data=0, stall=0, pending_count=0.
- Write 0xDEADBEEF to r7, read r7 next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Issue load to r3, next cycle rs_addr=3 -> stall=1 and pending_count=1.
  - WB load write of 0x55 to r3 in a later cycle, REGFILE_BYPASS_EN defined -> stall=0 that same cycle and rs_data=0x55.
  - Same sequence, macro undefined -> stall=0 one cycle later.
- Same cycle: load issue to r9 and WB load clear of r9 -> pend[9] stays 1 and pending_count is unchanged.
- Loads issued to r1, r2, r4 -> pending_count=3. Assert reset mid-sequence -> pending_count=0, stall=0, all registers 0 on the next cycle.
- Load issued to r0 -> no pend bit set, pending_count=0, rs_addr=0 never stalls.
